// File: rtl/encoder_sample_sequencer.sv
// Sequences encoder snapshot captures: periodic/software trigger, done handshake,
// sample latching with step delta, timeout and overrun accounting.
module encoder_sample_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned OVR_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [31:0]      sample_period,
  input  logic             sw_trigger,
  input  logic             clear_err,
  output logic             enc_trigger,
  input  logic             enc_done,
  input  logic [31:0]      enc_steps,
  input  logic [31:0]      enc_position,
  output logic [31:0]      sample_steps,
  output logic [31:0]      sample_delta,
  output logic [31:0]      sample_position,
  output logic             sample_valid,
  output logic [31:0]      sample_count,
  output logic             busy,
  output logic             timeout_err,
  output logic [OVR_W-1:0] overrun_cnt
);

  localparam int unsigned WCNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);
  localparam logic [OVR_W-1:0]  OVR_ONE   = OVR_W'(1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_TRIG = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [31:0]       period_cnt_q, period_cnt_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              first_sample_q, first_sample_d;
  logic              done_dly_q, done_dly_d;
  logic [31:0]       sample_steps_q, sample_steps_d;
  logic [31:0]       sample_delta_q, sample_delta_d;
  logic [31:0]       sample_position_q, sample_position_d;
  logic              sample_valid_q, sample_valid_d;
  logic [31:0]       sample_count_q, sample_count_d;
  logic              timeout_err_q, timeout_err_d;
  logic [OVR_W-1:0]  overrun_cnt_q, overrun_cnt_d;

  logic timer_on;
  logic tick;
  logic request;
  logic rise;
  logic in_flight;
  logic overrun_evt;
  logic timeout_evt;

  always_comb begin
    timer_on     = enable && (sample_period != '0);
    tick         = timer_on && (period_cnt_q == sample_period - 32'd1);
    period_cnt_d = '0;
    if (timer_on) begin
      period_cnt_d = tick ? '0 : period_cnt_q + 32'd1;
    end

    request    = tick | sw_trigger;
    rise       = enc_done & ~done_dly_q;
    done_dly_d = enc_done;
    in_flight  = (state_q == ST_TRIG) || (state_q == ST_WAIT);

    state_d           = state_q;
    wait_cnt_d        = wait_cnt_q;
    first_sample_d    = first_sample_q;
    sample_steps_d    = sample_steps_q;
    sample_delta_d    = sample_delta_q;
    sample_position_d = sample_position_q;
    sample_count_d    = sample_count_q;
    sample_valid_d    = 1'b0;
    timeout_evt       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (request) begin
          state_d = ST_TRIG;
        end
      end
      ST_TRIG: begin
        wait_cnt_d = '0;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        // A done edge on the final wait cycle still completes the sample.
        if (rise) begin
          sample_steps_d    = enc_steps;
          sample_position_d = enc_position;
          sample_delta_d    = first_sample_q ? '0 : enc_steps - sample_steps_q;
          first_sample_d    = 1'b0;
          sample_count_d    = sample_count_q + 32'd1;
          sample_valid_d    = 1'b1;
          state_d           = ST_IDLE;
        end else if (wait_cnt_q == WAIT_LAST) begin
          timeout_evt = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + WCNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    overrun_evt = request && in_flight;

    // Same-cycle events take priority over clear_err.
    if (clear_err) begin
      timeout_err_d = timeout_evt;
      overrun_cnt_d = overrun_evt ? OVR_ONE : '0;
    end else begin
      timeout_err_d = timeout_err_q | timeout_evt;
      overrun_cnt_d = overrun_cnt_q;
      if (overrun_evt && (overrun_cnt_q != '1)) begin
        overrun_cnt_d = overrun_cnt_q + OVR_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q           <= ST_IDLE;
      period_cnt_q      <= '0;
      wait_cnt_q        <= '0;
      first_sample_q    <= 1'b1;
      done_dly_q        <= 1'b0;
      sample_steps_q    <= '0;
      sample_delta_q    <= '0;
      sample_position_q <= '1;
      sample_valid_q    <= 1'b0;
      sample_count_q    <= '0;
      timeout_err_q     <= 1'b0;
      overrun_cnt_q     <= '0;
    end else begin
      state_q           <= state_d;
      period_cnt_q      <= period_cnt_d;
      wait_cnt_q        <= wait_cnt_d;
      first_sample_q    <= first_sample_d;
      done_dly_q        <= done_dly_d;
      sample_steps_q    <= sample_steps_d;
      sample_delta_q    <= sample_delta_d;
      sample_position_q <= sample_position_d;
      sample_valid_q    <= sample_valid_d;
      sample_count_q    <= sample_count_d;
      timeout_err_q     <= timeout_err_d;
      overrun_cnt_q     <= overrun_cnt_d;
    end
  end

  assign enc_trigger     = (state_q == ST_TRIG);
  assign busy            = (state_q == ST_TRIG) || (state_q == ST_WAIT);
  assign sample_steps    = sample_steps_q;
  assign sample_delta    = sample_delta_q;
  assign sample_position = sample_position_q;
  assign sample_valid    = sample_valid_q;
  assign sample_count    = sample_count_q;
  assign timeout_err     = timeout_err_q;
  assign overrun_cnt     = overrun_cnt_q;

endmodule

// File: tb/tb_encoder_sample_sequencer.sv
// Self-checking bench: directed vector table, hand-written corner sequences and
// randomized traffic against a timestamp-based reference model.
module tb_encoder_sample_sequencer;

  localparam int unsigned TO      = 64;
  localparam int unsigned OW      = 4;
  localparam int unsigned OVR_MAX = (1 << OW) - 1;

  logic          clk = 1'b0;
  logic          rst_n, enable, sw_trigger, clear_err, enc_done;
  logic [31:0]   sample_period, enc_steps, enc_position;
  logic          enc_trigger, sample_valid, busy, timeout_err;
  logic [31:0]   sample_steps, sample_delta, sample_position, sample_count;
  logic [OW-1:0] overrun_cnt;

  always #5 clk = ~clk;

  encoder_sample_sequencer #(
    .TIMEOUT_CYCLES(TO),
    .OVR_W(OW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sample_period(sample_period),
    .sw_trigger(sw_trigger), .clear_err(clear_err), .enc_trigger(enc_trigger),
    .enc_done(enc_done), .enc_steps(enc_steps), .enc_position(enc_position),
    .sample_steps(sample_steps), .sample_delta(sample_delta),
    .sample_position(sample_position), .sample_valid(sample_valid),
    .sample_count(sample_count), .busy(busy), .timeout_err(timeout_err),
    .overrun_cnt(overrun_cnt)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Driven values for the next cycle.
  bit          drv_rst_n, drv_en, drv_sw, drv_clr;
  logic [31:0] drv_period, drv_steps, drv_pos;
  bit          rand_mode;
  int          enc_lat;
  int          done_at;
  int          done_hold;
  int          cyc;
  int unsigned trig_seen;

  // Reference model: a sequence is "in flight" from its trigger cycle m_t until it ends.
  int unsigned m_timer;
  bit          m_done_prev, m_in_seq, m_first, m_terr, m_valid;
  int          m_t;
  logic [31:0] m_steps, m_delta, m_pos, m_count;
  int unsigned m_ovr;

  typedef struct {
    bit          en;
    logic [31:0] period;
    bit          sw;
    int          lat;
    logic [31:0] steps;
    logic [31:0] pos;
    int          run;
    bit          clr_after;
    logic [31:0] e_count;
    logic [31:0] e_steps;
    logic [31:0] e_delta;
    logic [31:0] e_pos;
    bit          e_terr;
    int unsigned e_ovr;
  } vec_t;

  vec_t vt[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_timer = 0; m_done_prev = 0; m_in_seq = 0; m_first = 1; m_terr = 0; m_valid = 0;
    m_t = -10; m_steps = '0; m_delta = '0; m_pos = 32'hFFFF_FFFF; m_count = '0; m_ovr = 0;
  endtask

  task automatic model_step();
    bit tmr_on, tick, req, rise, to_ev, ov_ev;
    if (!drv_rst_n) begin
      model_reset();
      return;
    end
    tmr_on  = drv_en && (drv_period != 0);
    tick    = tmr_on && (m_timer == drv_period - 32'd1);
    m_timer = (!tmr_on || tick) ? 0 : m_timer + 1;
    req     = tick || drv_sw;
    rise    = enc_done && !m_done_prev;
    m_done_prev = enc_done;
    m_valid = 0; to_ev = 0; ov_ev = 0;
    if (m_in_seq) begin
      ov_ev = req;
      if (cyc > m_t) begin
        if (rise) begin
          m_delta  = m_first ? 32'd0 : enc_steps - m_steps;
          m_steps  = enc_steps;
          m_pos    = enc_position;
          m_first  = 0;
          m_count  = m_count + 32'd1;
          m_valid  = 1;
          m_in_seq = 0;
        end else if (cyc - m_t == int'(TO)) begin
          to_ev    = 1;
          m_in_seq = 0;
        end
      end
    end else if (req) begin
      m_in_seq = 1;
      m_t      = cyc + 1;
    end
    if (drv_clr) begin
      m_terr = to_ev;
      m_ovr  = ov_ev ? 1 : 0;
    end else begin
      if (to_ev) m_terr = 1;
      if (ov_ev && m_ovr < OVR_MAX) m_ovr++;
    end
  endtask

  // Check current outputs, then apply the driven inputs for this cycle.
  task automatic cycle();
    bit exp_trig;
    int lat;
    @(negedge clk);
    exp_trig = m_in_seq && (cyc == m_t);
    chk("enc_trigger", enc_trigger, exp_trig);
    chk("busy", busy, m_in_seq);
    chk("sample_valid", sample_valid, m_valid);
    chk("sample_steps", sample_steps, m_steps);
    chk("sample_delta", sample_delta, m_delta);
    chk("sample_position", sample_position, m_pos);
    chk("sample_count", sample_count, m_count);
    chk("timeout_err", timeout_err, m_terr);
    chk("overrun_cnt", overrun_cnt, m_ovr);
    if (enc_trigger === 1'b1) trig_seen++;

    rst_n         = drv_rst_n;
    enable        = drv_en;
    sample_period = drv_period;
    sw_trigger    = drv_sw;
    clear_err     = drv_clr;
    enc_steps     = rand_mode ? $urandom : drv_steps;
    enc_position  = rand_mode ? $urandom : drv_pos;
    if (exp_trig) begin
      lat       = rand_mode ? int'($urandom_range(1, TO + 2)) : enc_lat;
      done_at   = (lat > 0) ? cyc + lat : -1;
      done_hold = rand_mode ? int'($urandom_range(1, 3)) : 2;
    end
    enc_done = (done_at >= 0) && (cyc >= done_at) && (cyc < done_at + done_hold);
    model_step();
    cyc++;
  endtask

  task automatic idle(input int n);
    drv_sw = 0; drv_clr = 0; drv_en = 0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic sw_pulse();
    drv_sw = 1;
    cycle();
    drv_sw = 0;
  endtask

  initial begin
    int unsigned t0;
    rst_n = 0; enable = 0; sample_period = '0; sw_trigger = 0; clear_err = 0;
    enc_done = 0; enc_steps = '0; enc_position = '0;
    drv_rst_n = 0; drv_en = 0; drv_sw = 0; drv_clr = 0;
    drv_period = '0; drv_steps = '0; drv_pos = '0;
    rand_mode = 0; enc_lat = 3; done_at = -1; done_hold = 2; cyc = 0; trig_seen = 0;
    model_reset();

    //        en   period  sw  lat steps     pos     run clr  count steps    delta          pos    terr ovr
    vt[0] = '{1'b0, 32'd0,  1'b1, 3, 32'd100,  32'd7,   10, 1'b0, 32'd1, 32'd100,  32'd0,          32'd7,   1'b0, 0};
    vt[1] = '{1'b1, 32'd10, 1'b0, 3, 32'd95,   32'd200, 15, 1'b0, 32'd2, 32'd95,   32'hFFFF_FFFB,  32'd200, 1'b0, 0};
    vt[2] = '{1'b0, 32'd0,  1'b1, 0, 32'd555,  32'd9,   70, 1'b1, 32'd2, 32'd95,   32'hFFFF_FFFB,  32'd200, 1'b1, 0};
    vt[3] = '{1'b1, 32'd5,  1'b0, 20, 32'd1000, 32'd33, 27, 1'b0, 32'd3, 32'd1000, 32'd905,        32'd33,  1'b0, 4};
    vt[4] = '{1'b1, 32'd1,  1'b0, 20, 32'd1003, 32'd34, 22, 1'b0, 32'd4, 32'd1003, 32'd3,          32'd34,  1'b0, 15};

    cycle();
    drv_rst_n = 1;
    idle(4);

    for (int i = 0; i < 5; i++) begin
      drv_steps = vt[i].steps; drv_pos = vt[i].pos; enc_lat = vt[i].lat;
      drv_period = vt[i].period;
      for (int k = 0; k < vt[i].run; k++) begin
        drv_en = vt[i].en;
        drv_sw = vt[i].sw && (k == 0);
        cycle();
      end
      idle(3);
      chk($sformatf("vec%0d_count", i), sample_count, vt[i].e_count);
      chk($sformatf("vec%0d_steps", i), sample_steps, vt[i].e_steps);
      chk($sformatf("vec%0d_delta", i), sample_delta, vt[i].e_delta);
      chk($sformatf("vec%0d_pos", i), sample_position, vt[i].e_pos);
      chk($sformatf("vec%0d_terr", i), timeout_err, vt[i].e_terr);
      chk($sformatf("vec%0d_ovr", i), overrun_cnt, vt[i].e_ovr);
      if (vt[i].clr_after) begin
        drv_clr = 1;
        cycle();
        drv_clr = 0;
      end
    end

    // clear_err coinciding with an overrun: the overrun wins.
    enc_lat = 5;
    sw_pulse();
    idle(2);
    drv_sw = 1; drv_clr = 1;
    cycle();
    idle(12);
    chk("clr_vs_ovr_cnt", overrun_cnt, 1);
    chk("clr_vs_ovr_count", sample_count, 5);

    // Tick and sw_trigger in the same cycle form one request.
    drv_clr = 1;
    cycle();
    drv_clr = 0;
    t0 = trig_seen;
    enc_lat = 3; drv_period = 32'd4;
    for (int k = 0; k < 4; k++) begin
      drv_en = 1;
      drv_sw = (k == 3);
      cycle();
    end
    idle(12);
    chk("tick_sw_triggers", trig_seen - t0, 1);
    chk("tick_sw_ovr", overrun_cnt, 0);
    chk("tick_sw_count", sample_count, 6);

    // Done edge on the final wait cycle: captured, no timeout.
    enc_lat = TO; drv_steps = 32'd2000;
    sw_pulse();
    idle(72);
    chk("edge_at_timeout_count", sample_count, 7);
    chk("edge_at_timeout_terr", timeout_err, 0);
    chk("edge_at_timeout_delta", sample_delta, 32'd997);

    // Reset while waiting, then first sample after reset reports zero delta.
    enc_lat = 10;
    sw_pulse();
    idle(4);
    drv_rst_n = 0;
    cycle();
    drv_rst_n = 1;
    cycle();
    chk("rst_count", sample_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_trig", enc_trigger, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_steps", sample_steps, 0);
    chk("rst_delta", sample_delta, 0);
    chk("rst_pos", sample_position, 32'hFFFF_FFFF);
    chk("rst_terr", timeout_err, 0);
    chk("rst_ovr", overrun_cnt, 0);
    idle(12);
    enc_lat = 3; drv_steps = 32'd777; drv_pos = 32'd5;
    sw_pulse();
    idle(10);
    chk("post_rst_count", sample_count, 1);
    chk("post_rst_steps", sample_steps, 32'd777);
    chk("post_rst_delta", sample_delta, 0);

    // Randomized traffic against the model.
    rand_mode = 1;
    for (int n = 0; n < 4000; n++) begin
      if (n % 150 == 0) begin
        drv_en = ($urandom_range(0, 9) < 7);
        case ($urandom_range(0, 9))
          0:       drv_period = 32'd0;
          1:       drv_period = 32'd1;
          default: drv_period = $urandom_range(2, 90);
        endcase
      end else if ($urandom_range(0, 99) == 0) begin
        drv_period = $urandom_range(1, 40);
      end
      drv_sw    = ($urandom_range(0, 9) == 0);
      drv_clr   = ($urandom_range(0, 39) == 0);
      drv_rst_n = ($urandom_range(0, 599) != 0);
      cycle();
    end
    drv_rst_n = 1;
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/encoder_sample_sequencer.md
Name: encoder_sample_sequencer

Overview:
- Sequences snapshot captures from one encoder interface block, driving its one-cycle `trigger` and waiting for its `done` handshake.
- Generates the trigger from a programmable periodic timer or a software pulse, then latches the synced steps and position.
- Computes the step delta since the previous sample for velocity estimation.
- Sits between the encoder interface and the AXI register file; flags timeouts and overruns.

Parameters:
- TIMEOUT_CYCLES, 64, max cycles in WAIT for an `enc_done` rising edge before aborting (>=2).
- OVR_W, 16, width of the saturating overrun counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- enable  in  1  periodic timer enable
- sample_period  in  32  timer period in clk cycles; 0 disables periodic ticks
- sw_trigger  in  1  one-cycle software sample request
- clear_err  in  1  clears timeout_err and overrun_cnt
- enc_trigger  out  1  one-cycle trigger to the encoder interface
- enc_done  in  1  encoder done level
- enc_steps  in  32  encoder steps_synced
- enc_position  in  32  encoder position_synced
- sample_steps  out  32  latched steps
- sample_delta  out  32  sample_steps minus previous sample_steps, mod 2^32 (two's complement)
- sample_position  out  32  latched position
- sample_valid  out  1  one-cycle pulse per completed sample
- sample_count  out  32  completed samples, wraps
- busy  out  1  high in TRIG or WAIT
- timeout_err  out  1  sticky timeout flag
- overrun_cnt  out  OVR_W  dropped requests, saturating

Behaviour:
- All state changes on posedge clk. rst_n low at an edge resets everything, including mid-sequence.
- Reset values:
  - enc_trigger=0, sample_valid=0, busy=0, timeout_err=0, overrun_cnt=0, sample_count=0.
  - sample_steps=0, sample_delta=0, sample_position=32'hFFFFFFFF.
  - period counter=0, state=IDLE, first_sample=1, enc_done_d=0.
- Timer:
  - When enable=1 and sample_period!=0, the counter increments each cycle.
  - tick=1 when counter==sample_period-1; the counter then wraps to 0.
  - When enable=0 or sample_period==0, the counter holds 0 and tick=0.
  - sample_period=1 gives a tick every cycle.
- request = tick | sw_trigger. A tick and sw_trigger in the same cycle form one request.
- Rising-edge detect: enc_done_d <= enc_done; rise = enc_done & ~enc_done_d.
- FSM states: IDLE, TRIG, WAIT.
  - IDLE: on request, go to TRIG.
  - TRIG: enc_trigger=1 for exactly this cycle; wait counter cleared; go to WAIT. Latency: request at edge N means enc_trigger is high in cycle N+1.
  - WAIT, rise detected: at that edge, latch sample_steps<=enc_steps and sample_position<=enc_position.
    - sample_delta <= first_sample ? 0 : enc_steps - sample_steps; then first_sample<=0.
    - sample_count+1; sample_valid high the following cycle; go to IDLE.
  - WAIT, no rise: the wait counter increments. When it reaches TIMEOUT_CYCLES-1, set timeout_err=1 and go to IDLE; sample outputs and sample_count stay unchanged.
  - WAIT, rise and timeout in the same cycle: rise wins, and timeout_err is not set.
- busy=1 in TRIG and WAIT.
- Overrun: a request while in TRIG or WAIT is dropped and increments overrun_cnt, saturating at 2^OVR_W-1.
  - A request in the cycle WAIT exits still counts as an overrun.
  - A request in IDLE is never dropped.
- clear_err: clears timeout_err and overrun_cnt. If an overrun or timeout event occurs in the same cycle, the event wins (flag set, count = 1).
- Deasserting enable does not abort an in-flight sequence; sw_trigger still works with enable=0.
- Changing sample_period mid-count takes effect on the next compare. A counter already >= the new period-1 counts up and wraps at 2^32.

Test Plan:
1. Reset, then sw_trigger pulse with an encoder model that raises done 3 cycles after trigger, enc_steps=100, enc_position=7 -> enc_trigger one cycle after the request; sample_valid pulse; sample_steps=100, sample_delta=0, sample_position=7, sample_count=1.
2. enable=1, sample_period=10, steps 100 then 95 -> enc_trigger every 10 cycles; second sample sample_delta=32'hFFFFFFFB; sample_count increments per sample.
3. Encoder model never raises done, TIMEOUT_CYCLES=64 -> timeout_err=1 after 64 WAIT cycles; busy falls; sample_count and sample outputs unchanged. Then clear_err -> timeout_err=0.
4. Model done latency 20, sample_period=5 -> each tick during TRIG/WAIT counts an overrun (overrun_cnt=4 per sample); with OVR_W=4, forcing 20 overruns saturates at 15.
5. Tick and sw_trigger in the same cycle -> a single enc_trigger, overrun_cnt=0. Done rise in the same cycle as the timeout -> sample captured, timeout_err=0.
6. rst_n low for one cycle while in WAIT -> all outputs at reset values next cycle; the following sample reports sample_delta=0 (first_sample re-armed).
